spi_slave_sequencer: RTL and testbench

Control FSM for the SPI slave memory front end. Consumes chip-select and SCLK edge pulses already cleaned by the input conditioners and sequences the external shift register, address latch and data memory through a 16-bit frame: 7-bit address, R/W bit, then 8 data bits. It owns no datapath storage beyond its bit counter; it issues single-cycle enables only.

---
 rtl/spi_seq_pkg.sv | 24 ++
 rtl/spi_bit_counter.sv | 33 +++
 rtl/spi_slave_sequencer.sv | 173 +++++++++++++++++
 tb/tb_spi_slave_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg
//   Shared definitions for the SPI slave sequencer: frame field widths,
//   bit-counter width, R/W encoding and the FSM state enumeration.
//   No ports (package).
package spi_seq_pkg;

  localparam int   ADDR_BITS = 7;
  localparam int   DATA_BITS = 8;
  localparam int   CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic RW_READ   = 1'b1;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    GET_ADDR     = 4'd1,
    DECODE       = 4'd2,
    READ_WAIT    = 4'd3,
    READ_LOAD    = 4'd4,
    READ_SEND    = 4'd5,
    WRITE_GET    = 4'd6,
    WRITE_COMMIT = 4'd7,
    DONE         = 4'd8
  } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter
//   Frame bit counter: synchronous clear, increment, saturation at all-ones,
//   and a terminal-count compare against a caller-supplied value.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   clr             clear to zero (wins over inc)
//   inc             increment by one (holds at all-ones)
//   tc_value        value that the terminal-count compare matches
//   tc              high while count == tc_value
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tc_value,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == tc_value);

endmodule

// File: rtl/spi_slave_sequencer.sv
// spi_slave_sequencer
//   Control FSM for the SPI slave memory front end. Sequences a 16-bit frame
//   (7-bit address, R/W bit, 8 data bits) by issuing single-cycle enables to
//   the external shift register, address latch and data memory.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   cs_n            conditioned chip select, active low
//   sclk_rise/fall  one-cycle SCLK edge pulses
//   rw_bit          shift register bit 0 (1 = read)
//   sr_shift        shift-register serial shift enable
//   sr_load         shift-register parallel load
//   addr_we         address latch write enable
//   dm_we           data memory write enable
//   miso_en         MISO tristate enable
//   busy            FSM not in IDLE
//   abort_pulse     one-cycle pulse per mid-frame abort
//   abort_count     saturating abort count
// Build option: SPI_SEQ_ABORT_STATUS_EN enables abort_pulse/abort_count;
//   when undefined both are tied to zero.
module spi_slave_sequencer
  import spi_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sclk_rise,
  input  logic       sclk_fall,
  input  logic       rw_bit,
  output logic       sr_shift,
  output logic       sr_load,
  output logic       addr_we,
  output logic       dm_we,
  output logic       miso_en,
  output logic       busy,
  output logic       abort_pulse,
  output logic [7:0] abort_count
);

  state_t           state;
  logic             abort;
  logic             fall_eff;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_tc_value;

  assign abort    = cs_n && (state != IDLE) && (state != DONE);
  // A coincident rise takes precedence, so a fall is only acted on alone.
  assign fall_eff = sclk_fall && !sclk_rise;

  // The compare looks at the count before the increment, so tc on an active
  // edge means this edge is the last one of the phase.
  always_comb begin
    cnt_clr      = abort || (state == IDLE) || (state == DECODE);
    cnt_inc      = 1'b0;
    cnt_tc_value = CNT_W'(DATA_BITS - 1);
    case (state)
      GET_ADDR: begin
        cnt_inc      = sclk_rise;
        cnt_tc_value = CNT_W'(ADDR_BITS);
      end
      WRITE_GET: cnt_inc = sclk_rise;
      READ_SEND: cnt_inc = fall_eff;
      default:   cnt_inc = 1'b0;
    endcase
  end

  spi_bit_counter #(.W(CNT_W)) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .tc_value (cnt_tc_value),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr_shift <= 1'b0;
      sr_load  <= 1'b0;
      addr_we  <= 1'b0;
      dm_we    <= 1'b0;
      miso_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sr_shift <= 1'b0;
      sr_load  <= 1'b0;
      addr_we  <= 1'b0;
      dm_we    <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        miso_en <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!cs_n) begin
              state <= GET_ADDR;
              busy  <= 1'b1;
            end
          end
          GET_ADDR: begin
            if (sclk_rise) begin
              sr_shift <= 1'b1;
              if (cnt_tc) begin
                state   <= DECODE;
                addr_we <= 1'b1;
              end
            end
          end
          DECODE:    state <= (rw_bit == RW_READ) ? READ_WAIT : WRITE_GET;
          READ_WAIT: begin
            state   <= READ_LOAD;
            sr_load <= 1'b1;
          end
          READ_LOAD: begin
            state   <= READ_SEND;
            miso_en <= 1'b1;
          end
          READ_SEND: begin
            if (fall_eff) begin
              sr_shift <= 1'b1;
              if (cnt_tc) begin
                state   <= DONE;
                miso_en <= 1'b0;
              end
            end
          end
          WRITE_GET: begin
            if (sclk_rise) begin
              sr_shift <= 1'b1;
              if (cnt_tc) begin
                state <= WRITE_COMMIT;
                dm_we <= 1'b1;
              end
            end
          end
          WRITE_COMMIT: state <= DONE;
          DONE: begin
            if (cs_n) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            miso_en <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPI_SEQ_ABORT_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      abort_pulse <= 1'b0;
      abort_count <= 8'd0;
    end else begin
      abort_pulse <= abort;
      if (abort && (abort_count != 8'hFF)) begin
        abort_count <= abort_count + 8'd1;
      end
    end
  end
`else
  assign abort_pulse = 1'b0;
  assign abort_count = 8'd0;
`endif

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// tb_spi_slave_sequencer
//   Directed self-checking bench for spi_slave_sequencer. Expectations follow
//   SPI_SEQ_ABORT_STATUS_EN when it is defined for the build.
module tb_spi_slave_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk_rise = 1'b0;
  logic       sclk_fall = 1'b0;
  logic       rw_bit = 1'b0;
  logic       sr_shift, sr_load, addr_we, dm_we, miso_en, busy, abort_pulse;
  logic [7:0] abort_count;

  int n_assert = 0;
  int n_fail   = 0;
  int n_shift  = 0;
  int n_load   = 0;
  int n_addr   = 0;
  int n_dm     = 0;
  int n_ap     = 0;
  int base_shift, base_load, base_dm, base_ap;

`ifdef SPI_SEQ_ABORT_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  always #10 clk = ~clk;

  spi_slave_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cs_n        (cs_n),
    .sclk_rise   (sclk_rise),
    .sclk_fall   (sclk_fall),
    .rw_bit      (rw_bit),
    .sr_shift    (sr_shift),
    .sr_load     (sr_load),
    .addr_we     (addr_we),
    .dm_we       (dm_we),
    .miso_en     (miso_en),
    .busy        (busy),
    .abort_pulse (abort_pulse),
    .abort_count (abort_count)
  );

  always @(negedge clk) begin
    if (sr_shift)    n_shift++;
    if (sr_load)     n_load++;
    if (addr_we)     n_addr++;
    if (dm_we)       n_dm++;
    if (abort_pulse) n_ap++;
  end

  function automatic logic [5:0] strobes();
    return {sr_shift, sr_load, addr_we, dm_we, miso_en, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rise();
    sclk_rise = 1'b1;
    tick();
    sclk_rise = 1'b0;
  endtask

  task automatic fall();
    sclk_fall = 1'b1;
    tick();
    sclk_fall = 1'b0;
  endtask

  // Drops cs_n and clocks in the 8-bit address/RW byte; ends one cycle
  // after the DECODE cycle.
  task automatic send_addr(input logic rw);
    rw_bit = rw;
    cs_n   = 1'b0;
    tick();
    chk("cs_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      rise();
      chk("addr_shift", sr_shift, 1);
      chk("addr_we_timing", addr_we, (i == 7));
      tick();
    end
    chk("post_decode_strobes", strobes(), 6'b000001);
  endtask

  initial begin
    // reset
    tick();
    tick();
    chk("reset_strobes", strobes(), 6'b000000);
    chk("reset_abort_pulse", abort_pulse, 0);
    chk("reset_abort_count", abort_count, 0);
    reset = 1'b0;
    tick();
    chk("idle_strobes", strobes(), 6'b000000);

    // write frame: addr 0x2A, rw 0, data 0xC5
    base_shift = n_shift;
    base_dm    = n_dm;
    send_addr(1'b0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      rise();
      chk("wr_shift", sr_shift, 1);
      chk("wr_dm_we_timing", dm_we, (i == 7));
      tick();
    end
    chk("wr_done_strobes", strobes(), 6'b000001);
    rise();
    chk("wr_done_ignores_rise", sr_shift, 0);
    tick();
    chk("wr_total_shifts", n_shift - base_shift, 16);
    chk("wr_dm_we_count", n_dm - base_dm, 1);
    cs_n = 1'b1;
    tick();
    chk("wr_release", strobes(), 6'b000000);

    // read frame: addr 0x13, rw 1
    base_load = n_load;
    base_dm   = n_dm;
    send_addr(1'b1);
    tick();
    chk("rd_sr_load", strobes(), 6'b010001);
    tick();
    chk("rd_send_strobes", strobes(), 6'b000011);
    base_shift = n_shift;
    rise();
    chk("rd_ignores_rise", sr_shift, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      fall();
      chk("rd_fall_shift", sr_shift, 1);
      chk("rd_miso_en", miso_en, (i != 7));
      tick();
    end
    chk("rd_data_shifts", n_shift - base_shift, 8);
    chk("rd_load_count", n_load - base_load, 1);
    chk("rd_no_dm_we", n_dm - base_dm, 0);
    chk("rd_done_strobes", strobes(), 6'b000001);
    cs_n = 1'b1;
    tick();
    chk("rd_release", strobes(), 6'b000000);

    // coincident rise and fall in GET_ADDR
    rw_bit = 1'b0;
    cs_n   = 1'b0;
    tick();
    base_shift = n_shift;
    sclk_rise  = 1'b1;
    sclk_fall  = 1'b1;
    tick();
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    chk("coinc_shift", sr_shift, 1);
    tick();
    chk("coinc_single_shift", n_shift - base_shift, 1);
    for (int i = 0; i < 7; i++) begin
      rise();
      chk("coinc_addr_we", addr_we, (i == 6));
      tick();
    end
    cs_n = 1'b1;
    tick();
    chk("coinc_abort_strobes", strobes(), 6'b000000);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_clears_count", abort_count, 0);

    // write abort after 4 data bits
    base_dm = n_dm;
    send_addr(1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rise();
      tick();
    end
    cs_n = 1'b1;
    tick();
    chk("wabort_strobes", strobes(), 6'b000000);
    chk("wabort_pulse", abort_pulse, STATUS_EN);
    chk("wabort_count", abort_count, STATUS_EN ? 1 : 0);
    tick();
    chk("wabort_pulse_once", abort_pulse, 0);
    chk("wabort_no_dm_we", n_dm - base_dm, 0);

    // cs_n rising with the final data edge
    base_dm = n_dm;
    send_addr(1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      rise();
      tick();
    end
    sclk_rise = 1'b1;
    cs_n      = 1'b1;
    tick();
    sclk_rise = 1'b0;
    chk("final_abort_strobes", strobes(), 6'b000000);
    tick();
    chk("final_abort_no_dm_we", n_dm - base_dm, 0);
    chk("final_abort_count", abort_count, STATUS_EN ? 2 : 0);

    // reset during READ_SEND
    send_addr(1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      fall();
      tick();
    end
    chk("rs_miso_before_reset", miso_en, 1);
    reset     = 1'b1;
    sclk_fall = 1'b1;
    tick();
    sclk_fall = 1'b0;
    chk("rs_strobes", strobes(), 6'b000000);
    chk("rs_abort_pulse", abort_pulse, 0);
    chk("rs_abort_count", abort_count, 0);
    cs_n  = 1'b1;
    reset = 1'b0;
    tick();
    base_dm    = n_dm;
    base_shift = n_shift;
    send_addr(1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      rise();
      chk("rs_wr_dm_we", dm_we, (i == 7));
      tick();
    end
    chk("rs_wr_shifts", n_shift - base_shift, 16);
    chk("rs_wr_dm_count", n_dm - base_dm, 1);
    cs_n = 1'b1;
    tick();
    chk("rs_wr_release", strobes(), 6'b000000);

    // 300 aborted frames
    base_ap = n_ap;
    for (int i = 0; i < 300; i++) begin
      cs_n = 1'b0;
      tick();
      tick();
      cs_n = 1'b1;
      tick();
    end
    tick();
    chk("sat_abort_count", abort_count, STATUS_EN ? 255 : 0);
    chk("sat_abort_pulses", n_ap - base_ap, STATUS_EN ? 300 : 0);
    chk("sat_idle_strobes", strobes(), 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
